reset_sequencer: RTL and testbench



---
 rtl/reset_seq_pkg.sv | 20 ++
 rtl/seq_timer.sv | 32 +++
 rtl/reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_reset_sequencer.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_seq_pkg.sv
// Shared types and default timing for the staged reset release sequencer.
package reset_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD    = 3'd0,
    ST_RELEASE = 3'd1,
    ST_WAIT    = 3'd2,
    ST_GAP     = 3'd3,
    ST_DONE    = 3'd4
  } seq_state_t;

  localparam int DEF_HOLD_CYCLES    = 16;
  localparam int DEF_GAP_CYCLES     = 4;
  localparam int DEF_TIMEOUT_CYCLES = 64;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_timer.sv
// Saturating up-counter with clear/load/enable and a terminal compare,
// time-shared by the hold, wait and gap phases of the sequencer.
module seq_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  input  logic [W-1:0] term_val,
  output logic         at_term
);

  logic [W-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clr) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en && (count != '1)) begin
      count <= count + W'(1);
    end
  end

  assign at_term = (count >= term_val);

endmodule

// File: rtl/reset_sequencer.sv
// Releases NUM_STAGES reset domains one at a time, waiting for each
// stage's ready before the next; a soft reset restarts the sequence.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int   NUM_STAGES       = 4,
  parameter int   CNT_WIDTH        = 8,
  parameter int   HOLD_CYCLES      = DEF_HOLD_CYCLES,
  parameter int   GAP_CYCLES       = DEF_GAP_CYCLES,
  parameter int   TIMEOUT_CYCLES   = DEF_TIMEOUT_CYCLES,
  parameter logic RST_OUT_POLARITY = 1'b1,
  localparam int  IDX_W            = idx_width(NUM_STAGES)
) (
  input  logic                  clkIn,
  input  logic                  rstIn,
  input  logic                  swRstReqIn,
  input  logic [NUM_STAGES-1:0] stageReadyIn,
  output logic [NUM_STAGES-1:0] rstOut,
  output logic                  seqDoneOut,
  output logic                  swRstAckOut,
  output logic [IDX_W-1:0]      activeStageOut,
  output logic [NUM_STAGES-1:0] timeoutErrOut
);

  localparam logic [CNT_WIDTH-1:0] HOLD_TERM =
    CNT_WIDTH'(HOLD_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] TMO_TERM =
    CNT_WIDTH'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] GAP_TERM =
    CNT_WIDTH'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX =
    IDX_W'(NUM_STAGES - 1);
  localparam logic [NUM_STAGES-1:0] ALL_ON =
    {NUM_STAGES{RST_OUT_POLARITY}};

  seq_state_t            state;
  logic [IDX_W-1:0]      idx;
  logic [NUM_STAGES-1:0] rst_q;
  logic [NUM_STAGES-1:0] err_q;
  logic                  done_q;
  logic                  ack_q;

  logic [NUM_STAGES-1:0] sel;
  logic                  ready_now;
  logic                  last_stage;
  logic                  tmr_clr;
  logic                  tmr_load;
  logic                  tmr_en;
  logic                  at_term;
  logic [CNT_WIDTH-1:0]  term_val;

  assign sel        = NUM_STAGES'(1) << idx;
  assign ready_now  = |(stageReadyIn & sel);
  assign last_stage = (idx == LAST_IDX);

  // A zero gap still spends one edge in GAP before moving on.
  always_comb begin
    term_val = '0;
    tmr_clr  = 1'b0;
    tmr_load = 1'b0;
    tmr_en   = 1'b0;
    unique case (state)
      ST_HOLD: begin
        term_val = HOLD_TERM;
        tmr_en   = 1'b1;
      end
      ST_RELEASE: tmr_clr = 1'b1;
      ST_WAIT: begin
        term_val = TMO_TERM;
        tmr_en   = 1'b1;
        tmr_clr  = ready_now || at_term;
      end
      ST_GAP: begin
        term_val = GAP_TERM;
        tmr_en   = 1'b1;
      end
      ST_DONE: tmr_load = swRstReqIn;
      default: tmr_clr = 1'b1;
    endcase
  end

  seq_timer #(
    .W(CNT_WIDTH)
  ) u_timer (
    .clk      (clkIn),
    .rst_n    (rstIn),
    .clr      (tmr_clr),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val ('0),
    .term_val (term_val),
    .at_term  (at_term)
  );

  always_ff @(posedge clkIn or negedge rstIn) begin
    if (!rstIn) begin
      state  <= ST_HOLD;
      idx    <= '0;
      rst_q  <= ALL_ON;
      err_q  <= '0;
      done_q <= 1'b0;
      ack_q  <= 1'b0;
    end else begin
      ack_q <= 1'b0;
      unique case (state)
        ST_HOLD: begin
          if (at_term) state <= ST_RELEASE;
        end
        ST_RELEASE: begin
          rst_q <= (rst_q & ~sel) | (~ALL_ON & sel);
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          if (ready_now) begin
            state <= ST_GAP;
          end else if (at_term) begin
            err_q <= err_q | sel;
            state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (at_term) begin
            if (last_stage) begin
              state <= ST_DONE;
            end else begin
              idx   <= idx + IDX_W'(1);
              state <= ST_RELEASE;
            end
          end
        end
        ST_DONE: begin
          if (swRstReqIn) begin
            rst_q  <= ALL_ON;
            done_q <= 1'b0;
            ack_q  <= 1'b1;
            idx    <= '0;
            state  <= ST_HOLD;
          end else begin
            rst_q  <= ~ALL_ON;
            done_q <= 1'b1;
          end
        end
        default: state <= ST_HOLD;
      endcase
    end
  end

  assign rstOut         = rst_q;
  assign seqDoneOut     = done_q;
  assign swRstAckOut    = ack_q;
  assign activeStageOut = idx;
  assign timeoutErrOut  = err_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Randomized bench: release times derived arithmetically from per-stage
// ready latencies, compared every cycle against the sequencer outputs.
module tb_reset_sequencer;

  localparam int NS   = 4;
  localparam int HOLD = 16;
  localparam int GAP  = 4;
  localparam int TMO  = 64;
  localparam int G    = (GAP > 0) ? GAP : 1;

  logic          clk = 1'b0;
  logic          rstIn;
  logic          swRstReqIn;
  logic [NS-1:0] stageReadyIn;
  logic [NS-1:0] rstOut;
  logic          seqDoneOut;
  logic          swRstAckOut;
  logic [1:0]    activeStageOut;
  logic [NS-1:0] timeoutErrOut;

  logic req2, ready2, rst2, done2, ack2, act2, err2;

  int checks = 0;
  int errors = 0;

  int            r[NS];
  int            rel[NS];
  int            done_e;
  logic [NS-1:0] exp_err;

  always #5 clk = ~clk;

  reset_sequencer #(
    .NUM_STAGES(NS), .CNT_WIDTH(8), .HOLD_CYCLES(HOLD),
    .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TMO), .RST_OUT_POLARITY(1'b1)
  ) u_dut (
    .clkIn(clk), .rstIn(rstIn), .swRstReqIn(swRstReqIn),
    .stageReadyIn(stageReadyIn), .rstOut(rstOut),
    .seqDoneOut(seqDoneOut), .swRstAckOut(swRstAckOut),
    .activeStageOut(activeStageOut), .timeoutErrOut(timeoutErrOut)
  );

  reset_sequencer #(
    .NUM_STAGES(1), .CNT_WIDTH(8), .HOLD_CYCLES(1),
    .GAP_CYCLES(0), .TIMEOUT_CYCLES(TMO), .RST_OUT_POLARITY(1'b1)
  ) u_small (
    .clkIn(clk), .rstIn(rstIn), .swRstReqIn(req2),
    .stageReadyIn(ready2), .rstOut(rst2),
    .seqDoneOut(done2), .swRstAckOut(ack2),
    .activeStageOut(act2), .timeoutErrOut(err2)
  );

  function automatic int rand_r();
    if ($urandom_range(0, 5) == 0) return $urandom_range(TMO - 1, TMO + 6);
    return $urandom_range(1, 10);
  endfunction

  // mode 0: req high only for edges <= pre; 1: random req before DONE;
  // 2: req raised before DONE and held, soft reset expected at done_e.
  task automatic run_seq(input int mode, input int pre,
                         input int stop_stage, input int stop_off);
    int wv[NS];
    int last_e, s, act;
    logic [NS-1:0] xr;
    logic xd, xa;
    logic [1:0] xact;
    rel[0] = HOLD + 1;
    for (int i = 0; i < NS; i++) begin
      wv[i] = (r[i] <= TMO) ? r[i] : TMO;
      if (i < NS - 1) rel[i+1] = rel[i] + wv[i] + G + 1;
      else done_e = rel[i] + wv[i] + G + 1;
    end
    last_e = (mode == 2) ? done_e : done_e + 2;
    if (stop_stage >= 0) last_e = rel[stop_stage] + stop_off;
    s = $urandom_range(1, done_e - 1);
    for (int e = 1; e <= last_e; e++) begin
      @(negedge clk);
      for (int i = 0; i < NS; i++) begin
        if (e > rel[i] && e <= rel[i] + wv[i])
          stageReadyIn[i] = (e - rel[i] >= r[i]);
        else
          stageReadyIn[i] = 1'($urandom_range(0, 1));
      end
      case (mode)
        1: swRstReqIn = (e < done_e) ? 1'($urandom_range(0, 1)) : 1'b0;
        2: swRstReqIn = (e >= s);
        default: swRstReqIn = (e <= pre);
      endcase
      @(posedge clk);
      #1;
      for (int i = 0; i < NS; i++)
        if (r[i] > TMO && e == rel[i] + TMO) exp_err[i] = 1'b1;
      if (mode == 2 && e == done_e) begin
        xr = '1; xd = 1'b0; xa = 1'b1; xact = 2'd0;
      end else begin
        for (int i = 0; i < NS; i++) xr[i] = (e < rel[i]);
        xd = (e >= done_e);
        xa = 1'b0;
        act = 0;
        for (int i = 1; i < NS; i++) if (e >= rel[i] - 1) act = i;
        xact = 2'(act);
      end
      checks++;
      if (rstOut !== xr) begin
        errors++;
        $display("FAIL seq_rstOut e=%0d got=%b exp=%b", e, rstOut, xr);
      end
      checks++;
      if (seqDoneOut !== xd) begin
        errors++;
        $display("FAIL seq_done e=%0d got=%b exp=%b", e, seqDoneOut, xd);
      end
      checks++;
      if (swRstAckOut !== xa) begin
        errors++;
        $display("FAIL seq_ack e=%0d got=%b exp=%b", e, swRstAckOut, xa);
      end
      checks++;
      if (activeStageOut !== xact) begin
        errors++;
        $display("FAIL seq_active e=%0d got=%0d exp=%0d",
                 e, activeStageOut, xact);
      end
      checks++;
      if (timeoutErrOut !== exp_err) begin
        errors++;
        $display("FAIL seq_timeout e=%0d got=%b exp=%b",
                 e, timeoutErrOut, exp_err);
      end
    end
  endtask

  task automatic do_soft_reset();
    @(negedge clk);
    swRstReqIn = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (rstOut !== 4'hF || swRstAckOut !== 1'b1 || seqDoneOut !== 1'b0) begin
      errors++;
      $display("FAIL soft_reset rst=%b ack=%b done=%b exp rst=1111 ack=1 done=0",
               rstOut, swRstAckOut, seqDoneOut);
    end
    checks++;
    if (activeStageOut !== 2'd0 || timeoutErrOut !== exp_err) begin
      errors++;
      $display("FAIL soft_reset_state act=%0d err=%b exp act=0 err=%b",
               activeStageOut, timeoutErrOut, exp_err);
    end
  endtask

  task automatic test_reset();
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (rstOut !== 4'hF || seqDoneOut !== 1'b0 || swRstAckOut !== 1'b0) begin
      errors++;
      $display("FAIL reset_outs rst=%b done=%b ack=%b exp 1111 0 0",
               rstOut, seqDoneOut, swRstAckOut);
    end
    checks++;
    if (activeStageOut !== 2'd0 || timeoutErrOut !== 4'h0) begin
      errors++;
      $display("FAIL reset_state act=%0d err=%b exp 0 0000",
               activeStageOut, timeoutErrOut);
    end
  endtask

  task automatic test_power_on();
    for (int i = 0; i < NS; i++) r[i] = 1;
    exp_err = '0;
    rstIn = 1'b1;
    run_seq(0, 0, -1, 0);
  endtask

  task automatic test_timeout();
    r[0] = 3; r[1] = TMO; r[2] = TMO + 1; r[3] = 2;
    do_soft_reset();
    run_seq(0, 1, -1, 0);
    checks++;
    if (timeoutErrOut !== 4'b0100) begin
      errors++;
      $display("FAIL timeout_flags got=%b exp=0100", timeoutErrOut);
    end
  endtask

  task automatic test_soft_reset();
    for (int i = 0; i < NS; i++) r[i] = $urandom_range(1, 8);
    do_soft_reset();
    run_seq(0, 1, -1, 0);
  endtask

  task automatic test_req_ignored();
    for (int i = 0; i < NS; i++) r[i] = $urandom_range(1, 8);
    do_soft_reset();
    run_seq(1, 1, -1, 0);
  endtask

  task automatic test_req_into_done();
    for (int i = 0; i < NS; i++) r[i] = $urandom_range(1, 8);
    do_soft_reset();
    run_seq(2, 1, -1, 0);
    for (int i = 0; i < NS; i++) r[i] = rand_r();
    run_seq(0, 0, -1, 0);
  endtask

  task automatic test_random();
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < NS; i++) r[i] = rand_r();
      do_soft_reset();
      run_seq(0, 1, -1, 0);
    end
  endtask

  task automatic test_async_reset();
    r[0] = TMO + 6; r[1] = TMO + 6; r[2] = 1; r[3] = 1;
    do_soft_reset();
    run_seq(0, 1, 1, 3);
    #2 rstIn = 1'b0;
    #1;
    checks++;
    if (rstOut !== 4'hF || seqDoneOut !== 1'b0 || swRstAckOut !== 1'b0) begin
      errors++;
      $display("FAIL async_outs rst=%b done=%b ack=%b exp 1111 0 0",
               rstOut, seqDoneOut, swRstAckOut);
    end
    checks++;
    if (activeStageOut !== 2'd0 || timeoutErrOut !== 4'h0) begin
      errors++;
      $display("FAIL async_state act=%0d err=%b exp 0 0000",
               activeStageOut, timeoutErrOut);
    end
    exp_err = '0;
    swRstReqIn = 1'b0;
    repeat (3) @(posedge clk);
    #1 rstIn = 1'b1;
    for (int i = 0; i < NS; i++) r[i] = rand_r();
    run_seq(0, 0, -1, 0);
  endtask

  task automatic test_min_config();
    int r2, d2;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk);
      #1 rstIn = 1'b0;
      req2 = 1'b0;
      #1;
      checks++;
      if (rst2 !== 1'b1 || done2 !== 1'b0) begin
        errors++;
        $display("FAIL min_reset rst=%b done=%b exp 1 0", rst2, done2);
      end
      repeat (2) @(posedge clk);
      #1 rstIn = 1'b1;
      r2 = (k == 0) ? 1 : $urandom_range(1, 6);
      d2 = 2 + r2 + 2;
      for (int e = 1; e <= d2 + 1; e++) begin
        @(negedge clk);
        if (e > 2 && e <= 2 + r2) ready2 = (e - 2 >= r2);
        else ready2 = 1'($urandom_range(0, 1));
        @(posedge clk);
        #1;
        checks++;
        if (rst2 !== (e < 2) || done2 !== (e >= d2)) begin
          errors++;
          $display("FAIL min_seq e=%0d rst=%b done=%b exp rst=%b done=%b",
                   e, rst2, done2, (e < 2), (e >= d2));
        end
        checks++;
        if (ack2 !== 1'b0 || act2 !== 1'b0 || err2 !== 1'b0) begin
          errors++;
          $display("FAIL min_misc e=%0d ack=%b act=%b err=%b exp 0 0 0",
                   e, ack2, act2, err2);
        end
      end
    end
  endtask

  initial begin
    rstIn        = 1'b0;
    swRstReqIn   = 1'b0;
    stageReadyIn = '0;
    req2         = 1'b0;
    ready2       = 1'b0;
    exp_err      = '0;
    test_reset();
    test_power_on();
    test_timeout();
    test_soft_reset();
    test_req_ignored();
    test_req_into_done();
    test_random();
    test_async_reset();
    test_min_config();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    errors++;
    $display("FAIL watchdog time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
